io_tile_cfg_array: RTL and testbench

Parametrised, multi-channel I/O logical tile for the FPGA fabric periphery, generalising the single-pad I/O tile to NUM_IO pads that share one configuration-chain segment. Configuration bits are shifted into a shadow register and committed atomically to the active configuration, so pad direction and polarity never change while bits are in flight. The block sits between the SoC pad ring (gfpga_pad_io_soc_*) and the fabric routing (io_inpad/io_outpad), inside the periphery chain between upstream and downstream tiles.

---
 rtl/io_tile_cfg_array.sv | 121 ++++++++++++
 tb/tb_io_tile_cfg_array.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_tile_cfg_array.sv
// Multi-channel periphery I/O tile: serial config chain into a shadow register,
// committed atomically into the active config that gates the pad/fabric paths.
module io_tile_cfg_array #(
    parameter int NUM_IO = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              isol_n,
    input  logic              ccff_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad
);

    localparam int CFG_BITS  = 2;
    localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0]   active_q, active_d;
    logic                   active_valid_q, active_valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cfg_err_q, cfg_err_d;

    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state_q        <= S_IDLE;
            shadow_q       <= '0;
            active_q       <= '0;
            active_valid_q <= 1'b0;
            cnt_q          <= '0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            cnt_q          <= cnt_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        active_valid_d = active_valid_q;
        cnt_d          = cnt_q;
        cfg_err_d      = cfg_err_q;

        // The chain shifts regardless of FSM state, including the COMMIT cycle.
        if (ccff_en) begin
            shadow_d = {ccff_head, shadow_q[CHAIN_LEN-1:1]};
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ccff_en) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (ccff_en) begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
                end else if (cnt_q == CNT_FULL) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d   = S_IDLE;
                    cfg_err_d = 1'b1;
                end
            end
            S_COMMIT: begin
                active_d       = shadow_q;
                active_valid_d = 1'b1;
                if (ccff_en) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ccff_tail = shadow_q[0];
    assign cfg_done  = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;

    // Unconfigured or isolated pads park as inputs with both data paths at 0.
    logic gate;
    assign gate = active_valid_q & isol_n;

    for (genvar k = 0; k < NUM_IO; k++) begin : g_lane
        logic dir, inv;
        assign dir = active_q[CFG_BITS*k];
        assign inv = active_q[CFG_BITS*k+1];
        assign gfpga_pad_io_soc_dir[k] = gate ? dir : 1'b1;
        assign gfpga_pad_io_soc_out[k] = (gate & ~dir) ? (io_outpad[k] ^ inv) : 1'b0;
        assign io_inpad[k]             = (gate & dir) ? (gfpga_pad_io_soc_in[k] ^ inv) : 1'b0;
    end

endmodule

// File: tb/tb_io_tile_cfg_array.sv
// Scoreboard bench for io_tile_cfg_array: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_io_tile_cfg_array;

    logic       prog_clk = 1'b0;
    logic       prog_reset, isol_n, ccff_en, ccff_head;
    logic       ccff_tail, cfg_done, cfg_err;
    logic [7:0] soc_in, soc_out, soc_dir, outpad, inpad;

    io_tile_cfg_array #(.NUM_IO(8)) dut (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .isol_n               (isol_n),
        .ccff_en              (ccff_en),
        .ccff_head            (ccff_head),
        .ccff_tail            (ccff_tail),
        .cfg_done             (cfg_done),
        .cfg_err              (cfg_err),
        .gfpga_pad_io_soc_in  (soc_in),
        .gfpga_pad_io_soc_out (soc_out),
        .gfpga_pad_io_soc_dir (soc_dir),
        .io_outpad            (outpad),
        .io_inpad             (inpad)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [7:0] dir;
        logic [7:0] out;
        logic [7:0] inp;
        logic       done;
        logic       err;
        logic       chk_tail;
        logic       tail;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Expectation describes the outputs during the current cycle (state after
    // the previous edge, with the inputs currently driven).
    task automatic expect_out(input string nm, input logic [7:0] d, input logic [7:0] o,
                              input logic [7:0] i, input logic dn, input logic er,
                              input logic ct, input logic tl);
        exp_t e;
        e.dir = d; e.out = o; e.inp = i; e.done = dn; e.err = er;
        e.chk_tail = ct; e.tail = tl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic clk();
        @(posedge prog_clk);
        #1;
    endtask

    always @(negedge prog_clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (soc_dir !== e.dir || soc_out !== e.out || inpad !== e.inp ||
                cfg_done !== e.done || cfg_err !== e.err ||
                (e.chk_tail && ccff_tail !== e.tail)) begin
                errors++;
                $display("FAIL %s: got dir=%h out=%h inpad=%h done=%b err=%b tail=%b, want dir=%h out=%h inpad=%h done=%b err=%b tail=%b(chk=%b)",
                         nm, soc_dir, soc_out, inpad, cfg_done, cfg_err, ccff_tail,
                         e.dir, e.out, e.inp, e.done, e.err, e.tail, e.chk_tail);
            end
        end
    end

    // Config A: ch0 out non-inv (00), ch1 in inv (11), ch2..7 in non-inv (01).
    // Config B: every channel out inverted (10).
    logic [15:0] cfg_a = 16'h555C;
    logic [15:0] cfg_b = 16'hAAAA;
    logic [31:0] pass_bits = {16'h0F0F, 16'hC3A5};
    logic [15:0] pass_p    = 16'hC3A5;

    task automatic load(input logic [15:0] cfg);
        for (int i = 0; i < 16; i++) begin
            ccff_en = 1'b1; ccff_head = cfg[i];
            clk();
        end
        ccff_en = 1'b0;
        clk();
        clk();
    endtask

    initial begin
        prog_reset = 1'b0; isol_n = 1'b1; ccff_en = 1'b0; ccff_head = 1'b1;
        soc_in = 8'hFF; outpad = 8'hFF;
        clk();
        clk();
        expect_out("reset", 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0);
        prog_reset = 1'b1; ccff_head = 1'b0;
        clk();
        expect_out("idle_after_reset", 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0);
        clk();

        // Full load of config A with a mid-burst and COMMIT-cycle look.
        for (int i = 0; i < 16; i++) begin
            ccff_en = 1'b1; ccff_head = cfg_a[i];
            if (i == 8) expect_out("load_a_mid", 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0);
            clk();
        end
        ccff_en = 1'b0;
        expect_out("load_a_full", 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0);
        clk();
        expect_out("commit_a", 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0);
        clk();
        outpad = 8'h01; soc_in = 8'h00;
        expect_out("done_a_out", 8'hFE, 8'h01, 8'h02, 1, 0, 1, 0);
        clk();
        outpad = 8'h00; soc_in = 8'h02;
        expect_out("done_a_inv", 8'hFE, 8'h00, 8'h00, 1, 0, 0, 0);
        clk();
        outpad = 8'hFF; soc_in = 8'hFF;
        expect_out("done_a_ones", 8'hFE, 8'h01, 8'hFC, 1, 0, 0, 0);
        clk();

        isol_n = 1'b0;
        expect_out("isolate", 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0);
        clk();
        isol_n = 1'b1;
        expect_out("isolate_release", 8'hFE, 8'h01, 8'hFC, 1, 0, 0, 0);
        clk();

        // Valid reshift to B: pads hold A until the COMMIT edge.
        outpad = 8'h0F; soc_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            ccff_en = 1'b1; ccff_head = cfg_b[i];
            if (i == 10) expect_out("reshift_mid", 8'hFE, 8'h01, 8'h02, 0, 0, 0, 0);
            clk();
        end
        ccff_en = 1'b0;
        expect_out("reshift_full", 8'hFE, 8'h01, 8'h02, 0, 0, 0, 0);
        clk();
        expect_out("reshift_commit", 8'hFE, 8'h01, 8'h02, 0, 0, 0, 0);
        clk();
        expect_out("done_b", 8'h00, 8'hF0, 8'h00, 1, 0, 1, 0);
        clk();

        // 32-bit pass-through: tail replays the first 16 head bits 16 cycles late.
        for (int i = 0; i < 32; i++) begin
            ccff_en = 1'b1; ccff_head = pass_bits[i];
            if (i >= 16) expect_out("pass_tail", 8'h00, 8'hF0, 8'h00, 0, 0, 1, pass_p[i-16]);
            clk();
        end
        ccff_en = 1'b0;
        expect_out("pass_end", 8'h00, 8'hF0, 8'h00, 0, 0, 1, 1);
        clk();
        expect_out("pass_err", 8'h00, 8'hF0, 8'h00, 0, 1, 0, 0);
        clk();

        // Reset after 7 shifts aborts everything.
        outpad = 8'hFF; soc_in = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            ccff_en = 1'b1; ccff_head = 1'b1;
            clk();
        end
        prog_reset = 1'b0;
        clk();
        expect_out("reset_mid_shift", 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0);
        prog_reset = 1'b1; ccff_en = 1'b0;
        clk();

        load(cfg_a);
        outpad = 8'h01; soc_in = 8'h00;
        expect_out("reload_a", 8'hFE, 8'h01, 8'h02, 1, 0, 1, 0);
        clk();

        // Short 15-bit burst: error, active config untouched.
        for (int i = 0; i < 15; i++) begin
            ccff_en = 1'b1; ccff_head = 1'b1;
            clk();
        end
        ccff_en = 1'b0;
        expect_out("short_shift", 8'hFE, 8'h01, 8'h02, 0, 0, 0, 0);
        clk();
        expect_out("short_err", 8'hFE, 8'h01, 8'h02, 0, 1, 0, 0);
        clk();
        outpad = 8'hFF; soc_in = 8'hFF;
        expect_out("short_hold", 8'hFE, 8'h01, 8'hFC, 0, 1, 0, 0);
        clk();

        clk();
        clk();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
